// File: rtl/serial_pattern_generator.sv
// serial_pattern_generator
//   Serializes a parallel word onto serial_pattern, LSB first, with enable
//   qualifying every valid bit. Words are taken over a valid/ready handshake;
//   a programmable idle gap (enable low) follows each word.
//
// Ports
//   clk            rising-edge clock
//   rstb           asynchronous reset, active-high
//   word_in        parallel word, bit 0 sent first
//   word_len       bits to send; 0 or >WIDTH means WIDTH
//   gap_cycles     idle cycles after the word
//   word_valid     word_in/word_len/gap_cycles valid
//   word_ready     a word can be accepted this cycle
//   serial_pattern serial data bit (0 whenever enable is low)
//   enable         high on every cycle carrying a bit
//   word_done      pulse on the cycle the last bit is driven
//   busy           high in SHIFT or GAP
//
// state | meaning
// IDLE  | waiting for a word, word_ready high
// SHIFT | driving bits of the latched word, enable high
// GAP   | enable low for the latched number of gap cycles
module serial_pattern_generator #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] word_in,
    input  logic [LEN_W-1:0] word_len,
    input  logic [7:0]       gap_cycles,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             serial_pattern,
    output logic             enable,
    output logic             word_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_cnt_q;
    logic [7:0]       gap_q;
    logic [7:0]       gap_cnt_q;
    logic             serial_q;
    logic             enable_q;
    logic             done_q;
    logic             ready_q;
    logic             busy_q;

    logic             xfer;
    logic             last_bit;
    logic [LEN_W-1:0] len_d;
    logic [LEN_W-1:0] bit_cnt_d;
    logic             done_d;
    logic             load_done_d;

    assign xfer     = word_valid && ready_q;
    assign last_bit = (bit_cnt_q == len_q - LEN_W'(1));

    always_comb begin
        len_d = word_len;
        if (word_len == '0 || word_len > LEN_W'(WIDTH)) begin
            len_d = LEN_W'(WIDTH);
        end
    end

    assign load_done_d = (len_d == LEN_W'(1));
    assign bit_cnt_d   = bit_cnt_q + LEN_W'(1);
    assign done_d      = (bit_cnt_d == len_q - LEN_W'(1));

    // Loading a word happens from IDLE and, with a zero gap, directly from
    // the last SHIFT cycle; both paths share the load values below.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            serial_q  <= 1'b0;
            enable_q  <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    serial_q <= 1'b0;
                    enable_q <= 1'b0;
                    done_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    if (xfer) begin
                        state_q   <= ST_SHIFT;
                        shift_q   <= word_in >> 1;
                        len_q     <= len_d;
                        bit_cnt_q <= '0;
                        gap_q     <= gap_cycles;
                        serial_q  <= word_in[0];
                        enable_q  <= 1'b1;
                        done_q    <= load_done_d;
                        ready_q   <= load_done_d && (gap_cycles == 8'd0);
                        busy_q    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        if (gap_q != 8'd0) begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= gap_q;
                            serial_q  <= 1'b0;
                            enable_q  <= 1'b0;
                            done_q    <= 1'b0;
                            ready_q   <= 1'b0;
                            busy_q    <= 1'b1;
                        end else if (xfer) begin
                            state_q   <= ST_SHIFT;
                            shift_q   <= word_in >> 1;
                            len_q     <= len_d;
                            bit_cnt_q <= '0;
                            gap_q     <= gap_cycles;
                            serial_q  <= word_in[0];
                            enable_q  <= 1'b1;
                            done_q    <= load_done_d;
                            ready_q   <= load_done_d && (gap_cycles == 8'd0);
                            busy_q    <= 1'b1;
                        end else begin
                            state_q  <= ST_IDLE;
                            serial_q <= 1'b0;
                            enable_q <= 1'b0;
                            done_q   <= 1'b0;
                            ready_q  <= 1'b1;
                            busy_q   <= 1'b0;
                        end
                    end else begin
                        serial_q  <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_d;
                        enable_q  <= 1'b1;
                        done_q    <= done_d;
                        ready_q   <= done_d && (gap_q == 8'd0);
                        busy_q    <= 1'b1;
                    end
                end
                ST_GAP: begin
                    serial_q <= 1'b0;
                    enable_q <= 1'b0;
                    done_q   <= 1'b0;
                    // Down-counter: the terminal count of 1 ends the gap so
                    // exactly gap cycles are spent here.
                    if (gap_cnt_q == 8'd1) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    serial_q <= 1'b0;
                    enable_q <= 1'b0;
                    done_q   <= 1'b0;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign serial_pattern = serial_q;
    assign enable         = enable_q;
    assign word_done      = done_q;
    assign word_ready     = ready_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
module tb_serial_pattern_generator;

    localparam int WIDTH = 8;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rstb;
    logic [WIDTH-1:0] word_in;
    logic [LEN_W-1:0] word_len;
    logic [7:0]       gap_cycles;
    logic             word_valid;
    logic             word_ready;
    logic             serial_pattern;
    logic             enable;
    logic             word_done;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Per-cycle expectation: {enable, serial_pattern, word_done, word_ready, busy}
    typedef logic [4:0] cyc_t;
    localparam cyc_t IDLE_C = 5'b00010;
    localparam cyc_t GAP_C  = 5'b00001;

    cyc_t        trace[$];
    int unsigned wdata[$];
    int          wlen[$];
    int          wgap[$];

    serial_pattern_generator #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .rstb           (rstb),
        .word_in        (word_in),
        .word_len       (word_len),
        .gap_cycles     (gap_cycles),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .serial_pattern (serial_pattern),
        .enable         (enable),
        .word_done      (word_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cyc_t outs();
        return {enable, serial_pattern, word_done, word_ready, busy};
    endfunction

    // Expected output stream from the word list: the current cycle is IDLE
    // with ready high, valid is held while words remain, each word emits its
    // bits, then either gap cycles plus one IDLE cycle or straight into the
    // next word when its gap is zero.
    task automatic build_trace();
        int n;
        trace.delete();
        trace.push_back(IDLE_C);
        n = wdata.size();
        for (int k = 0; k < n; k++) begin
            int len;
            len = (wlen[k] == 0 || wlen[k] > WIDTH) ? WIDTH : wlen[k];
            for (int i = 0; i < len; i++) begin
                logic b, last;
                b    = ((wdata[k] >> i) & 1) != 0;
                last = (i == len - 1);
                trace.push_back({1'b1, b, last, last && (wgap[k] == 0), 1'b1});
            end
            if (wgap[k] > 0) begin
                for (int g = 0; g < wgap[k]; g++) trace.push_back(GAP_C);
                trace.push_back(IDLE_C);
            end else if (k == n - 1) begin
                trace.push_back(IDLE_C);
            end
        end
        trace.push_back(IDLE_C);
        trace.push_back(IDLE_C);
    endtask

    task automatic drive_word(input int idx);
        word_in    = WIDTH'(wdata[idx]);
        word_len   = LEN_W'(wlen[idx]);
        gap_cycles = 8'(wgap[idx]);
        word_valid = 1'b1;
    endtask

    // Entry: just after a posedge, DUT in IDLE with word_ready high.
    task automatic run_seq(input string tag);
        int  idx;
        logic xfer;
        build_trace();
        idx = 0;
        if (wdata.size() > 0) drive_word(0);
        else word_valid = 1'b0;
        for (int t = 0; t < trace.size(); t++) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d {en,sp,done,rdy,busy}", tag, t), 32'(outs()), 32'(trace[t]));
            xfer = word_valid && word_ready;
            @(posedge clk);
            #1;
            if (xfer) begin
                idx++;
                if (idx < wdata.size()) drive_word(idx);
                else begin
                    word_valid = 1'b0;
                    word_in    = WIDTH'($urandom);
                    word_len   = LEN_W'($urandom);
                    gap_cycles = 8'($urandom);
                end
            end
        end
    endtask

    task automatic add_word(input int unsigned d, input int l, input int g);
        wdata.push_back(d);
        wlen.push_back(l);
        wgap.push_back(g);
    endtask

    task automatic clear_words();
        wdata.delete();
        wlen.delete();
        wgap.delete();
    endtask

    initial begin
        rstb       = 1'b1;
        word_in    = '0;
        word_len   = '0;
        gap_cycles = '0;
        word_valid = 1'b0;
        #12;
        check("reset outputs", 32'(outs()), 32'(5'b00000));
        @(posedge clk);
        @(negedge clk);
        check("reset held outputs", 32'(outs()), 32'(5'b00000));
        rstb = 1'b0;
        @(posedge clk);
        #1;
        check("ready after release", 32'(word_ready), 32'(1'b1));

        // Single 8-bit word, no gap
        clear_words();
        add_word(32'hB2, 8, 0);
        run_seq("b2_len8");

        // Word with gap, second word held valid during the gap
        clear_words();
        add_word(32'h5, 3, 4);
        add_word(32'h3, 3, 0);
        run_seq("gap4");

        // Back-to-back with no bubble
        clear_words();
        add_word(32'hA5, 8, 0);
        add_word(32'h3C, 8, 0);
        run_seq("b2b");

        // Length clamping
        clear_words();
        add_word(32'h96, 0, 1);
        add_word(32'h69, 15, 0);
        add_word(32'h1, 1, 0);
        add_word(32'h0, 1, 2);
        run_seq("clamp");

        // Repeated 101 stream as detector stimulus
        clear_words();
        for (int i = 0; i < 4; i++) add_word(32'h5, 3, 0);
        run_seq("rep101");

        // Reset during the 4th bit of a word
        word_in    = 8'hB2;
        word_len   = 4'd8;
        gap_cycles = 8'd0;
        word_valid = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid-word enable before reset", 32'(enable), 32'(1'b1));
        check("mid-word busy before reset", 32'(busy), 32'(1'b1));
        #2;
        rstb = 1'b1;
        #1;
        check("async reset outputs", 32'(outs()), 32'(5'b00000));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset hold outputs", 32'(outs()), 32'(5'b00000));
        rstb = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset idle", 32'(outs()), 32'(IDLE_C));
        clear_words();
        add_word(32'hB2, 8, 1);
        run_seq("after_reset");

        // Randomized word lists
        for (int r = 0; r < 4; r++) begin
            clear_words();
            for (int k = 0; k < 6; k++) begin
                int g;
                g = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 5));
                add_word($urandom, int'($urandom_range(0, 15)), g);
            end
            run_seq($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_pattern_generator.md
Name: serial_pattern_generator

Overview:
- Transmit side of the serial pattern interface: serializes a parallel word onto serial_pattern, LSB first, qualified by enable.
- Drives the same serial_pattern/enable pair that the pattern detector consumes, giving the detector a deterministic stimulus source in system and block benches.
- Words arrive over a valid/ready handshake. A programmable idle gap (enable low) follows each word.

Parameters:
- WIDTH, 8, maximum word length in bits (2..32).
- LEN_W, $clog2(WIDTH+1), width of word_len.

Ports:
- clk  input  1  rising-edge clock.
- rstb  input  1  reset, asynchronous, active-high (1 = reset asserted).
- word_in  input  WIDTH  parallel word to send, bit 0 sent first.
- word_len  input  LEN_W  number of bits to send, 1..WIDTH.
- gap_cycles  input  8  idle cycles (enable low) inserted after the word.
- word_valid  input  1  word_in/word_len/gap_cycles valid.
- word_ready  output  1  generator can accept a word this cycle.
- serial_pattern  output  1  serial data bit.
- enable  output  1  high on every cycle carrying a valid serial bit.
- word_done  output  1  one-cycle pulse on the cycle the last bit of a word is driven.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset values: serial_pattern=0, enable=0, word_done=0, busy=0, word_ready=0, FSM=IDLE. Shift register and counters clear to 0.
- Reset mid-word: the partial word is discarded. After reset deasserts, the block is in IDLE with word_ready=1 from the next clock edge.
- FSM states: IDLE, SHIFT, GAP. All outputs are registered.
- Handshake: a transfer occurs when word_valid && word_ready at a rising edge. The block samples word_in, word_len and gap_cycles only at that transfer. Changes to these inputs while busy are ignored.
- word_ready is high in IDLE. It is also high in SHIFT on the last-bit cycle when the latched gap equals 0, which allows back-to-back words. It is low otherwise.
- Length rule: word_len=0 or word_len>WIDTH is clamped to WIDTH.
- IDLE -> SHIFT on transfer. The first bit (word_in[0]) is driven with enable=1 on the cycle after the transfer edge, giving a latency of 1 clock.
- SHIFT:
  - Each cycle drives the next bit with enable=1. The bit counter counts 0..len-1.
  - On the bit len-1 cycle, word_done=1.
  - Next state after the last bit:
    - GAP if the latched gap is greater than 0.
    - SHIFT with the new word's bit 0, if the gap is 0 and a transfer occurred this cycle (no bubble).
    - IDLE otherwise.
- GAP: enable=0 and serial_pattern=0 for exactly gap cycles, then IDLE. word_valid is not accepted during GAP.
- serial_pattern is forced to 0 whenever enable=0. enable is never high outside SHIFT.
- busy=1 in SHIFT and GAP. In IDLE, busy=0.

Test Plan:
- Reset, then send word_in=8'b1011_0010, word_len=8, gap=0 → serial_pattern = 0,1,0,0,1,1,0,1 on 8 consecutive cycles with enable=1, starting 1 cycle after transfer. word_done is high on the 8th bit; then enable=0 and the block returns to IDLE.
- word_in=3'b101, word_len=3, gap=4, followed by a second word 3'b011 held valid → bits 1,0,1, then exactly 4 cycles with enable=0 and word_ready=0, then IDLE, then bits 1,1,0.
- Back-to-back: words 0xA5 and 0x3C, len=8, gap=0, word_valid held high → 16 consecutive enable=1 cycles with no bubble. word_done pulses on cycles 8 and 16.
- word_len=0 and word_len=15 (WIDTH=8) → both send 8 bits.
- Assert rstb for 2 cycles at the 4th bit of an 8-bit word → serial_pattern, enable, busy and word_done go to 0 immediately (asynchronously). word_ready=1 on the first edge after release. The next word is sent cleanly from bit 0.
- Loopback with the pattern detector (enable/serial_pattern connected): send 3'b101 repeatedly with gap=0 → pattern_detected asserts after each complete pattern. With enable held low, pattern_detected never asserts.
